// File: rtl/counter_sequencer.sv
// Sequencing controller for the shared up/down wrap counter: turns run/step/clear/mode
// into rate-limited one-cycle enable pulses and handles ping-pong and single-sweep modes.
module counter_sequencer #(
    parameter logic [4:0] MIN       = 5'd0,
    parameter logic [4:0] MAX       = 5'd20,
    parameter int         WIDTH     = $clog2(int'(MAX) + 1),
    parameter int         DIV       = 4,
    parameter int         DIV_WIDTH = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] count,
    output logic             enable,
    output logic             up,
    output logic             count_reset,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [DIV_WIDTH-1:0] prescaler, prescaler_next;
    logic                 dir, dir_next;
    logic                 step_q;
    logic                 tick, step_edge, event_hit, pulse, dir_eval;
    logic                 at_max, at_min;
    logic                 enable_next, up_next, count_reset_next, busy_next, done_next;

    assign at_max = (count == WIDTH'(MAX));
    assign at_min = (count == WIDTH'(MIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prescaler   <= '0;
            dir         <= 1'b1;
            step_q      <= 1'b0;
            enable      <= 1'b0;
            up          <= 1'b1;
            count_reset <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            prescaler   <= prescaler_next;
            dir         <= dir_next;
            step_q      <= step;
            enable      <= enable_next;
            up          <= up_next;
            count_reset <= count_reset_next;
            busy        <= busy_next;
            done        <= done_next;
        end
    end

    // A tick in RUN and an accepted step share one direction/pulse decision.
    always_comb begin
        tick      = (state == RUN) && (prescaler == DIV_WIDTH'(DIV - 1));
        step_edge = step & ~step_q;
        event_hit = tick || ((state == IDLE) && step_edge);
        dir_eval  = dir;
        pulse     = event_hit;
        case (mode)
            2'b00: dir_eval = 1'b1;
            2'b01: dir_eval = 1'b0;
            2'b10: begin
                if (dir && at_max)
                    dir_eval = 1'b0;
                else if (!dir && at_min)
                    dir_eval = 1'b1;
            end
            default: begin
                dir_eval = 1'b1;
                if (at_max)
                    pulse = 1'b0;
            end
        endcase

        state_next = state;
        case (state)
            IDLE: if (run) state_next = RUN;
            RUN: begin
                if (!run)
                    state_next = IDLE;
                else if (tick && (mode == 2'b11) && at_max)
                    state_next = DONE;
            end
            DONE: if (!run) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        prescaler_next = '0;
        if ((state == RUN) && (state_next == RUN))
            prescaler_next = tick ? '0 : prescaler + 1'b1;

        if (clear)
            dir_next = 1'b1;
        else if (event_hit)
            dir_next = dir_eval;
        else
            dir_next = dir;
    end

    always_comb begin
        enable_next      = pulse && !clear;
        up_next          = enable_next ? dir_eval : up;
        count_reset_next = clear;
        busy_next        = (state_next == RUN);
        done_next        = (state_next == DONE);
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed and randomized checks of counter_sequencer against a cycle-level reference
// model, with a behavioural wrap counter closing the loop on count.
module tb_counter_sequencer;

    localparam logic [4:0] MIN = 5'd0;
    localparam logic [4:0] MAX = 5'd20;
    localparam int         DIV = 4;

    logic       clk = 1'b0;
    logic       reset, run, step, clear;
    logic [1:0] mode;
    logic [4:0] cnt;
    logic       enable, up, count_reset, busy, done;
    logic       load;
    logic [4:0] load_val;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // reference model state
    bit m_active, m_finished, m_dir, m_prev_step;
    int m_phase;
    bit e_en, e_up, e_cr, e_busy, e_done;

    always #5 clk = ~clk;

    counter_sequencer #(.MIN(MIN), .MAX(MAX), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .clear(clear),
        .mode(mode), .count(cnt), .enable(enable), .up(up),
        .count_reset(count_reset), .busy(busy), .done(done)
    );

    // the counter instance this block controls
    always @(posedge clk) begin
        if (load)
            cnt <= load_val;
        else if (count_reset)
            cnt <= MIN;
        else if (enable)
            cnt <= up ? ((cnt == MAX) ? MIN : cnt + 5'd1) : ((cnt == MIN) ? MAX : cnt - 5'd1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        bit rise, tk, acc, ev, nd, give;
        if (reset) begin
            m_active = 0; m_finished = 0; m_phase = 0; m_dir = 1; m_prev_step = 0;
            e_en = 0; e_up = 1; e_cr = 0;
        end else begin
            rise = step && !m_prev_step;
            m_prev_step = step;
            tk  = m_active && ((m_phase % DIV) == DIV - 1);
            acc = !m_active && !m_finished && rise;
            ev  = tk || acc;
            nd  = m_dir;
            give = ev;
            if (mode == 2'd0) nd = 1;
            else if (mode == 2'd1) nd = 0;
            else if (mode == 2'd2) begin
                if (cnt == MAX && m_dir) nd = 0;
                else if (cnt == MIN && !m_dir) nd = 1;
            end else begin
                nd = 1;
                if (cnt == MAX) give = 0;
            end
            e_en = give && !clear;
            if (e_en) e_up = nd;
            e_cr = clear;
            if (clear) m_dir = 1;
            else if (ev) m_dir = nd;
            if (m_active) begin
                if (!run) m_active = 0;
                else if (tk && mode == 2'd3 && cnt == MAX) begin
                    m_active = 0; m_finished = 1;
                end else m_phase++;
            end else if (m_finished) begin
                if (!run) m_finished = 0;
            end else if (run) begin
                m_active = 1; m_phase = 0;
            end
        end
        e_busy = m_active;
        e_done = m_finished;
        @(posedge clk);
        #1;
        check("enable", enable, e_en);
        check("up", up, e_up);
        check("count_reset", count_reset, e_cr);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        if (enable === 1'b1) pulses++;
    endtask

    initial begin
        // reset held with every control asserted
        reset = 1; run = 1; step = 1; clear = 1; mode = 2'd0; load = 1; load_val = 5'd0;
        cycle();
        check("rst_enable", enable, 0);
        cycle();
        check("rst_enable2", enable, 0);
        check("rst_up", up, 1);
        reset = 0; run = 0; step = 0; clear = 0; load = 0;
        cycle();
        cycle();

        // up-wrap free run: pulses every DIV cycles
        run = 1; pulses = 0;
        for (int i = 1; i <= 14; i++) begin
            cycle();
            if (i == 5 || i == 9 || i == 13) check("t2_pulse", enable, 1);
        end
        check("t2_cnt", cnt, 3);
        check("t2_pulses", pulses, 3);
        run = 0;
        cycle();
        check("t2_busy_off", busy, 0);
        for (int i = 0; i < 6; i++) cycle();
        check("t2_no_more", pulses, 3);

        // ping-pong through the upper endpoint
        mode = 2'd2; load = 1; load_val = 5'd19;
        cycle();
        load = 0; run = 1;
        for (int i = 1; i <= 14; i++) begin
            cycle();
            if (i == 5)  check("t3_up1", up, 1);
            if (i == 6)  check("t3_cnt20", cnt, 20);
            if (i == 9)  check("t3_up2", up, 0);
            if (i == 10) check("t3_cnt19", cnt, 19);
            if (i == 13) check("t3_up3", up, 0);
            if (i == 14) check("t3_cnt18", cnt, 18);
        end
        run = 0;
        cycle();
        cycle();

        // single up-sweep stops at MAX
        mode = 2'd3; load = 1; load_val = 5'd18;
        cycle();
        load = 0; run = 1; pulses = 0;
        for (int i = 1; i <= 13; i++) begin
            cycle();
            if (i == 6)  check("t4_cnt19", cnt, 19);
            if (i == 10) check("t4_cnt20", cnt, 20);
        end
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_pulses", pulses, 2);
        run = 0;
        cycle();
        check("t4_done_off", done, 0);
        check("t4_cnt_hold", cnt, 20);

        // held step gives a single down pulse that wraps
        mode = 2'd1; load = 1; load_val = 5'd0;
        cycle();
        load = 0; step = 1; pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 1) begin
                check("t5_enable", enable, 1);
                check("t5_up", up, 0);
            end
        end
        check("t5_pulses", pulses, 1);
        check("t5_cnt", cnt, 20);
        step = 0;
        cycle();

        // clear coinciding with a tick
        mode = 2'd0; run = 1;
        for (int i = 1; i <= 10; i++) begin
            clear = (i == 5);
            cycle();
            if (i == 5) begin
                check("t6_cr", count_reset, 1);
                check("t6_en_suppressed", enable, 0);
            end
            if (i == 6)  check("t6_cnt0", cnt, 0);
            if (i == 9)  check("t6_next_up", up, 1);
            if (i == 9)  check("t6_next_en", enable, 1);
            if (i == 10) check("t6_cnt1", cnt, 1);
        end
        clear = 0; run = 0;
        cycle();
        cycle();

        // randomized controls against the reference model
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) == 0) run = ~run;
            step  = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 49) == 0);
            load_val = 5'($urandom_range(0, 20));
            cycle();
        end
        load = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Sequencing controller for the shared up/down wrap counter. It owns that counter's `up` and `enable` inputs and its synchronous clear. It converts operator controls (run, single-step, mode, clear) into rate-limited, one-cycle enable pulses, and it watches the counter value to implement ping-pong and single-sweep modes. It sits between the debounced front-panel inputs and the counter instance.

## Interface
- `MIN`, default 5'd0: counter lower bound; must match the counter instance.
- `MAX`, default 5'd20: counter upper bound; must match the counter instance.
- `WIDTH`, default $clog2(MAX+1): width of `count`.
- `DIV`, default 4: clk cycles between enable pulses in RUN; legal range is DIV >= 2.
- `DIV_WIDTH`, default $clog2(DIV): prescaler width.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `run` input 1: level; 1 = free-run, 0 = stop.
- `step` input 1: level; each rising edge requests one count step while idle.
- `clear` input 1: level; request a counter clear.
- `mode` input 2: 00 up-wrap, 01 down-wrap, 10 ping-pong, 11 single up-sweep.
- `count` input WIDTH: current value from the counter.
- `enable` output 1: counter enable, one-cycle pulse.
- `up` output 1: counter direction.
- `count_reset` output 1: drives the counter's reset.
- `busy` output 1: high while state is RUN.
- `done` output 1: high while state is DONE.

## Operation
- All outputs are registered.
- Reset values: enable=0, up=1, count_reset=0, busy=0, done=0. Internal reset values: state=IDLE, prescaler=0, dir=1, step_q=0.
- States:
  - IDLE → RUN when run=1.
  - RUN → IDLE when run=0; the prescaler clears on that transition.
  - RUN → DONE in mode 11 on a tick where count==MAX.
  - DONE → IDLE when run=0.
  - reset from any state → IDLE.
- Prescaler:
  - Cleared to 0 on entry to RUN.
  - Increments each RUN cycle and wraps at DIV-1.
  - A tick occurs in any RUN cycle where prescaler==DIV-1.
- Direction at a tick (or at an accepted step):
  - mode 00: dir=1.
  - mode 01: dir=0.
  - mode 10: if dir=1 and count==MAX, dir←0. If dir=0 and count==MIN, dir←1. Otherwise dir holds. The pulse uses the updated dir, so the endpoints are never repeated (…19,20,19…).
  - mode 11: dir=1. If count==MAX, no pulse is issued and the state goes to DONE.
- Pulse: the cycle after a tick, enable=1 and up=dir for exactly one cycle. `up` holds its last value otherwise.
- Wrap-around in modes 00/01 is performed by the counter itself. This block does not special-case the limits in those modes.
- Step:
  - step_q is the registered step; a rising edge is step & ~step_q.
  - Accepted only in IDLE; it produces one pulse the next cycle using the mode direction rules above.
  - In mode 11 at MAX, a step produces no pulse and does not enter DONE.
  - Steps are ignored in RUN and DONE. Holding step high gives a single pulse.
- Clear:
  - clear=1 makes count_reset=1 the next cycle, for as long as clear is held.
  - Any pulse that cycle is suppressed (enable=0).
  - Clear sets dir←1 and does not change state; the prescaler keeps running.
- Mode change while in RUN takes effect at the next tick. dir is preserved across IDLE/RUN transitions.
- run=0 and a tick in the same cycle: the state goes to IDLE and the pulse from that tick is still issued.

## Timing
- RUN entered at edge k: prescaler=0 in cycle k, tick in cycle k+DIV-1, enable high in cycle k+DIV, then every DIV cycles.
- The counter updates at the end of the enable cycle. Because DIV>=2, `count` is settled before the next tick.
- Step rising edge sampled at edge j: enable high in cycle j+1. Latency is 1 cycle.
- clear sampled at edge j: count_reset high in cycle j+1. Clear has priority over enable.
- busy and done follow the registered state with no extra latency.
- reset overrides all inputs; outputs take their reset values the cycle after the reset edge.

## Test plan
1. Assert reset for 2 cycles with run=step=clear=1 → enable=0, up=1, count_reset=0, busy=0, done=0; no pulses until reset is released.
2. DIV=4, mode 00, run held from count=0 → busy=1; enable pulses with up=1 at cycles k+4, k+8, k+12; counter reaches 3; drop run → no further pulses, busy=0 next cycle.
3. Mode 10, count=19, dir=1, run held → pulses up, down, down; count goes 19→20→19→18; dir flips at count 20.
4. Mode 11, count=18, run held → two up pulses (count reaches 20); at the next tick there is no pulse and done=1; drop run → done=0, state IDLE.
5. IDLE, mode 01, count=0, step held high for 10 cycles → exactly one enable with up=0 one cycle after the rising edge; count wraps to 20.
6. RUN, clear asserted in the same cycle as a tick → count_reset=1 and enable=0 that cycle; count becomes 0; the next tick pulses normally with up=1.
